// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : RISC-V load/store front end for a 64-bit doubleword memory.
//            Aligns accesses, does read-modify-write for sub-word stores,
//            extends load data and flags misaligned/illegal requests.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);

    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_ld  = 3'b011;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;
    localparam logic [2:0] c_f3_lwu = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic              r_write;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_wdata;
    logic              r_fault;
    logic [63:0]       r_rdata;

    logic              w_accept;
    logic              w_misaligned;
    logic              w_illegal;
    logic              w_req_fault;
    logic [2:0]        w_offset;
    logic [5:0]        w_shamt;
    logic [63:0]       w_rd_shift;
    logic [63:0]       w_load_ext;
    logic [7:0]        w_size_mask;
    logic [7:0]        w_lane_sel;
    logic [63:0]       w_wdata_shift;
    logic [63:0]       w_merged;

    // ------------------------------------------------------------------
    // Request legality, evaluated on the live request inputs at accept
    // ------------------------------------------------------------------
    assign w_accept = req_valid & (r_state == ST_IDLE);

    always_comb begin
        w_misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   w_misaligned = req_addr[0];
            2'b10:   w_misaligned = |req_addr[1:0];
            2'b11:   w_misaligned = |req_addr[2:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    // Stores have no unsigned variants, so funct3[2] set is always illegal.
    assign w_illegal   = req_write ? req_funct3[2] : (req_funct3 == 3'b111);
    assign w_req_fault = w_illegal | w_misaligned;

    // ------------------------------------------------------------------
    // Load extraction from the returned doubleword
    // ------------------------------------------------------------------
    assign w_offset   = r_addr[2:0];
    assign w_shamt    = {w_offset, 3'b000};
    assign w_rd_shift = mem_rdata >> w_shamt;

    always_comb begin
        w_load_ext = '0;
        case (r_funct3)
            c_f3_lb:  w_load_ext = {{56{w_rd_shift[7]}},  w_rd_shift[7:0]};
            c_f3_lh:  w_load_ext = {{48{w_rd_shift[15]}}, w_rd_shift[15:0]};
            c_f3_lw:  w_load_ext = {{32{w_rd_shift[31]}}, w_rd_shift[31:0]};
            c_f3_ld:  w_load_ext = w_rd_shift;
            c_f3_lbu: w_load_ext = {56'd0, w_rd_shift[7:0]};
            c_f3_lhu: w_load_ext = {48'd0, w_rd_shift[15:0]};
            c_f3_lwu: w_load_ext = {32'd0, w_rd_shift[31:0]};
            default:  w_load_ext = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Store merge: addressed lanes take store data, the rest keep memory
    // ------------------------------------------------------------------
    always_comb begin
        w_size_mask = 8'h00;
        case (r_funct3[1:0])
            2'b00:   w_size_mask = 8'h01;
            2'b01:   w_size_mask = 8'h03;
            2'b10:   w_size_mask = 8'h0F;
            default: w_size_mask = 8'hFF;
        endcase
    end

    assign w_lane_sel    = w_size_mask << w_offset;
    assign w_wdata_shift = r_wdata << w_shamt;

    genvar lane;
    generate
        for (lane = 0; lane < 8; lane++) begin : g_lane
            assign w_merged[8*lane +: 8] = w_lane_sel[lane] ? w_wdata_shift[8*lane +: 8]
                                                            : mem_rdata[8*lane +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_wdata    = '0;
        rsp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_req_fault) begin
                        w_next_state = ST_RESP;
                    end else if (req_write && (req_funct3 == c_f3_ld)) begin
                        w_next_state = ST_WRITE;
                    end else begin
                        w_next_state = ST_READ;
                    end
                end
            end
            ST_READ: begin
                mem_rd       = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                w_next_state = r_write ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                mem_wr       = 1'b1;
                mem_wdata    = r_wdata;
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid    = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Captured request and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_write  <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_fault  <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_accept) begin
                r_write  <= req_write;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_fault  <= w_req_fault;
            end
            if ((r_state == ST_WAIT) && r_write) begin
                r_wdata <= w_merged;
            end
            // Response data only changes on entry to RESP; only loads reach it from WAIT.
            if (w_next_state == ST_RESP) begin
                r_rdata <= (r_state == ST_WAIT) ? w_load_ext : 64'd0;
            end
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_fault = rsp_valid & r_fault;
    assign mem_addr  = {r_addr[ADDR_W-1:3], 3'b000};

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed vector bench for load_store_unit with a doubleword
//            memory model (one-cycle read latency, write at clock edge).
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_fault;
    logic [63:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    logic [63:0] mem [0:63];

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.ADDR_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr[8:3]];
        if (mem_wr) mem[mem_addr[8:3]] <= mem_wdata;
    end

    typedef struct {
        logic        write;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          rsp_cyc;
        int          rd_cyc;
        int          wr_cyc;
        logic        fault;
        logic [63:0] rdata;
        logic [63:0] mwdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic w, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input int rsp_c, input int rd_c,
                           input int wr_c, input logic flt, input logic [63:0] rdat,
                           input logic [63:0] mwd);
        vec_t v;
        v.write = w;  v.f3 = f3;  v.addr = a;  v.wdata = wd;
        v.rsp_cyc = rsp_c;  v.rd_cyc = rd_c;  v.wr_cyc = wr_c;
        v.fault = flt;  v.rdata = rdat;  v.mwdata = mwd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " ready"}, 64'(req_ready), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int rd_c = 0, wr_c = 0, rsp_c = 0, rd_n = 0, wr_n = 0, rsp_n = 0;
        logic [63:0] rd_a = '0, wr_a = '0, wd = '0, rdat = '0, hold = '0;
        logic flt = 1'b0, rdy_after = 1'b0;
        string nm;
        nm = $sformatf("vec%0d", idx);
        wait_ready(nm);
        req_write  = v.write;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (mem_rd)    begin rd_c = k;  rd_n++;  rd_a = mem_addr; end
            if (mem_wr)    begin wr_c = k;  wr_n++;  wr_a = mem_addr; wd = mem_wdata; end
            if (rsp_valid) begin rsp_c = k; rsp_n++; flt = rsp_fault; rdat = rsp_rdata; end
            if (k == v.rsp_cyc + 1) begin rdy_after = req_ready; hold = rsp_rdata; end
        end
        check({nm, " rsp_cycle"}, 64'(rsp_c), 64'(v.rsp_cyc));
        check({nm, " rsp_count"}, 64'(rsp_n), 64'd1);
        check({nm, " rd_cycle"},  64'(rd_c),  64'(v.rd_cyc));
        check({nm, " rd_count"},  64'(rd_n),  64'(v.rd_cyc != 0));
        check({nm, " wr_cycle"},  64'(wr_c),  64'(v.wr_cyc));
        check({nm, " wr_count"},  64'(wr_n),  64'(v.wr_cyc != 0));
        check({nm, " fault"},     64'(flt),   64'(v.fault));
        check({nm, " rdata"},     rdat,       v.rdata);
        check({nm, " rdata_hold"}, hold,      v.rdata);
        check({nm, " ready_after"}, 64'(rdy_after), 64'd1);
        if (v.rd_cyc != 0) check({nm, " rd_addr"}, rd_a, v.addr & ~64'h7);
        if (v.wr_cyc != 0) begin
            check({nm, " wr_addr"},  wr_a, v.addr & ~64'h7);
            check({nm, " wr_data"},  wd,   v.mwdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int act_n;
        logic [15:0] rd_mask, rsp_mask, rdy_mask;

        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[32]   = 64'h8877665544332211;   // 0x100
        mem[34]   = 64'hDEADBEEFCAFEBABE;   // 0x110
        mem_rdata = '0;

        // Requests are presented during reset and must be ignored.
        rst        = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b011;
        req_addr   = 64'h110;
        req_wdata  = 64'h1111111111111111;
        act_n = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_rd || mem_wr || rsp_valid) act_n++;
        end
        check("reset activity", 64'(act_n), 64'd0);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset rsp_rdata", rsp_rdata, 64'd0);
        check("reset rsp_fault", 64'(rsp_fault), 64'd0);
        check("reset mem_wdata", mem_wdata, 64'd0);
        check("reset ready", 64'(req_ready), 64'd1);
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("reset mem untouched", mem[34], 64'hDEADBEEFCAFEBABE);

        // write, f3, addr, wdata, rsp, rd, wr, fault, rdata, mem_wdata
        add_vec(0, 3'b000, 64'h107, 0, 3, 1, 0, 0, 64'hFFFFFFFFFFFFFF88, 0);
        add_vec(0, 3'b100, 64'h107, 0, 3, 1, 0, 0, 64'h0000000000000088, 0);
        add_vec(0, 3'b010, 64'h104, 0, 3, 1, 0, 0, 64'hFFFFFFFF88776655, 0);
        add_vec(0, 3'b110, 64'h104, 0, 3, 1, 0, 0, 64'h0000000088776655, 0);
        add_vec(0, 3'b001, 64'h102, 0, 3, 1, 0, 0, 64'h0000000000004433, 0);
        add_vec(0, 3'b011, 64'h100, 0, 3, 1, 0, 0, 64'h8877665544332211, 0);
        add_vec(0, 3'b101, 64'h106, 0, 3, 1, 0, 0, 64'h0000000000008877, 0);
        add_vec(0, 3'b001, 64'h106, 0, 3, 1, 0, 0, 64'hFFFFFFFFFFFF8877, 0);
        add_vec(1, 3'b001, 64'h102, 64'h00000000AAAABBBB, 4, 1, 3, 0, 0, 64'h88776655BBBB2211);
        add_vec(0, 3'b011, 64'h100, 0, 3, 1, 0, 0, 64'h88776655BBBB2211, 0);
        add_vec(1, 3'b011, 64'h108, 64'h0123456789ABCDEF, 2, 0, 1, 0, 0, 64'h0123456789ABCDEF);
        add_vec(1, 3'b000, 64'h10F, 64'hFFFFFFFFFFFFFF5A, 4, 1, 3, 0, 0, 64'h5A23456789ABCDEF);
        add_vec(1, 3'b010, 64'h10C, 64'h11223344CAFEF00D, 4, 1, 3, 0, 0, 64'hCAFEF00D89ABCDEF);
        add_vec(0, 3'b000, 64'h10C, 0, 3, 1, 0, 0, 64'h000000000000000D, 0);
        add_vec(0, 3'b010, 64'h10C, 0, 3, 1, 0, 0, 64'hFFFFFFFFCAFEF00D, 0);
        add_vec(0, 3'b001, 64'h10E, 0, 3, 1, 0, 0, 64'hFFFFFFFFFFFFCAFE, 0);
        add_vec(0, 3'b001, 64'h103, 0, 1, 0, 0, 1, 0, 0);
        add_vec(1, 3'b010, 64'h106, 64'h5555, 1, 0, 0, 1, 0, 0);
        add_vec(0, 3'b111, 64'h100, 0, 1, 0, 0, 1, 0, 0);
        add_vec(1, 3'b100, 64'h100, 64'h66, 1, 0, 0, 1, 0, 0);
        add_vec(0, 3'b011, 64'h104, 0, 1, 0, 0, 1, 0, 0);
        add_vec(0, 3'b100, 64'h101, 0, 3, 1, 0, 0, 64'h0000000000000022, 0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        check("mem 0x100 final", mem[32], 64'h88776655BBBB2211);
        check("mem 0x108 final", mem[33], 64'hCAFEF00D89ABCDEF);

        // SB abandoned by reset during WAIT
        wait_ready("abort");
        req_write  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 64'h110;
        req_wdata  = 64'h77;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort rd at T+1", 64'(mem_rd), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        act_n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_wr || rsp_valid) act_n++;
        end
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_wr || rsp_valid) act_n++;
        end
        check("abort activity", 64'(act_n), 64'd0);
        check("abort ready", 64'(req_ready), 64'd1);
        check("abort rsp_rdata", rsp_rdata, 64'd0);
        check("abort mem unchanged", mem[34], 64'hDEADBEEFCAFEBABE);

        // Back-to-back LD with req_valid held high: one accept every 4 cycles
        wait_ready("b2b");
        req_write  = 1'b0;
        req_funct3 = 3'b011;
        req_addr   = 64'h110;
        req_valid  = 1'b1;
        @(posedge clk);
        rd_mask = '0;  rsp_mask = '0;  rdy_mask = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            rd_mask[k]  = mem_rd;
            rsp_mask[k] = rsp_valid;
            rdy_mask[k] = req_ready;
            if (k == 11) check("b2b rdata", rsp_rdata, 64'hDEADBEEFCAFEBABE);
        end
        req_valid = 1'b0;
        check("b2b rd pattern",    64'(rd_mask),  64'h0222);
        check("b2b rsp pattern",   64'(rsp_mask), 64'h0888);
        check("b2b ready pattern", 64'(rdy_mask), 64'h1110);
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the multicycle datapath (ALU result register, register B) and the 64-bit data memory.
- Converts RISC-V load/store requests (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD) into doubleword-aligned memory accesses.
- Does read-modify-write for sub-word stores.
- Returns sign/zero-extended load data for the memory-data register, and flags misaligned or illegal accesses.

Parameters:
ADDR_W, 64, address width; data width is fixed at 64.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  unit can accept a request; high only in IDLE
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 of the load/store
req_addr  in  ADDR_W  byte address (ALU result)
req_wdata  in  64  store data (register B); low bytes used for sub-word stores
rsp_valid  out  1  one-cycle pulse: access complete
rsp_rdata  out  64  extended load data; 0 for stores and faults
rsp_fault  out  1  valid with rsp_valid: misaligned or illegal funct3
mem_addr  out  ADDR_W  {addr[ADDR_W-1:3],3'b000}
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe; memory writes at the clock edge ending the cycle
mem_wdata  out  64  full doubleword to write
mem_rdata  in  64  memory data; valid one cycle after mem_rd

Behaviour:
Reset:
- rst=0 sampled at an edge -> state IDLE; all captured request/data registers cleared.
- rsp_valid=0, rsp_rdata=0, rsp_fault=0; mem_rd, mem_wr and mem_wdata are 0 in IDLE.
- req_valid is ignored while rst=0.

Handshake:
- Accept when req_valid & req_ready at an edge; call that accept cycle T.
- addr, wdata, funct3 and write are captured at that edge; request inputs are ignored until IDLE is re-entered.
- There is no response backpressure.

Legality:
- Load funct3 000/001/010/011/100/101/110 are legal; 111 is illegal.
- Store funct3 000..011 are legal; others are illegal.
- Misaligned means the address is not aligned to the access size (half: addr[0]; word: addr[1:0]; double: addr[2:0]).
- Illegal or misaligned -> fault path. No mem_rd or mem_wr is asserted.

States: IDLE, READ, WAIT, WRITE, RESP.
- Load: T+1 READ (mem_rd=1); T+2 WAIT (extracted data latched); T+3 RESP.
- Sub-word store (SB/SH/SW): T+1 READ; T+2 WAIT (merged doubleword latched); T+3 WRITE (mem_wr=1, mem_wdata=merged); T+4 RESP.
- SD: T+1 WRITE (mem_wdata=req_wdata); T+2 RESP.
- Fault: T+1 RESP with rsp_fault=1.
- RESP lasts one cycle, then IDLE; req_ready=1 in the following cycle. Minimum spacing between accepts is two cycles (fault case).

Data rules (little-endian):
- Lane k = bits[8k+7:8k]; offset = addr[2:0].
- Load extract = doubleword >> (8*offset), truncated to the access size.
- Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU; LD unmodified.
- Store merge replaces only the addressed lanes with the low bytes of wdata; all other lanes keep mem_rdata.
- rsp_rdata holds its value until the next RESP.

Reset mid-operation:
- Abandons the access: no further mem_rd or mem_wr, and no rsp_valid.
- A WRITE cycle already in progress when rst is sampled completes at that same edge. This is a memory property, not a guarantee of the unit.

Test Plan:
- Preload memory 0x100 = 0x8877665544332211. Load LB at 0x107 -> rsp_valid at T+3, rsp_rdata=0xFFFFFFFFFFFFFF88, mem_rd only at T+1. LBU at 0x107 -> 0x0000000000000088.
- Same memory. LW at 0x104 -> 0xFFFFFFFF88776655; LWU at 0x104 -> 0x0000000088776655; LH at 0x102 -> 0x0000000000004433.
- SH at 0x102 with wdata 0x00000000AAAABBBB -> T+1 mem_rd at addr 0x100; T+3 mem_wr=1, mem_addr=0x100, mem_wdata=0x88776655BBBB2211; rsp_valid at T+4 with rsp_rdata=0, fault=0.
- SD at 0x108 with data 0x0123456789ABCDEF -> mem_rd never asserted; T+1 mem_wr with mem_wdata=0x0123456789ABCDEF; rsp_valid at T+2.
- LH at 0x103, SW at 0x106, load funct3=111 -> each gives rsp_valid at T+1 with rsp_fault=1, rsp_rdata=0, no mem_rd/mem_wr; req_ready high at T+2.
- SB accepted, rst=0 asserted during WAIT (T+2) -> mem_wr never asserted, no rsp_valid; after rst=1, req_ready=1 and memory unchanged. Back-to-back requests with req_valid held high are accepted only when req_ready=1.
